// File: rtl/vga_text_pkg.sv
// Shared constants, engine state type and logical-to-physical address mapping
// for the text-mode character buffer.
package vga_text_pkg;

    localparam int DEF_COLS   = 80;
    localparam int DEF_ROWS   = 30;
    localparam int DEF_CHAR_W = 8;
    localparam int DEF_ADDR_W = 12;
    localparam logic [7:0] DEF_BLANK = 8'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ALL = 2'd1,
        CLR_ROW = 2'd2
    } state_t;

    // One spare MSB keeps log+base from wrapping before the single DEPTH subtraction.
    function automatic logic [DEF_ADDR_W-1:0] log_to_phys(
        input logic [DEF_ADDR_W-1:0] log_addr,
        input logic [DEF_ADDR_W-1:0] base,
        input logic [DEF_ADDR_W:0]   depth
    );
        logic [DEF_ADDR_W:0] sum;
        sum = {1'b0, log_addr} + {1'b0, base};
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum[DEF_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/vga_text_buffer_ram.sv
// Simple dual-port character RAM: port A read-only, port B read-first write/read,
// both with one registered read stage.
module text_ram #(
    parameter int DEPTH  = 2400,
    parameter int CHAR_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr_a,
    output logic [CHAR_W-1:0] o_dout_a,
    input  logic              i_we_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [CHAR_W-1:0] i_din_b,
    output logic [CHAR_W-1:0] o_dout_b
);

    logic [CHAR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        o_dout_a <= r_mem[i_addr_a];
        o_dout_b <= r_mem[i_addr_b];
        if (i_we_b) begin
            r_mem[i_addr_b] <= i_din_b;
        end
    end

endmodule

// File: rtl/vga_text_buffer.sv
// Text-mode character buffer: fixed-latency VGA read port, req/ready CPU port,
// hardware row scroll and a full-screen clear engine.
module vga_text_buffer
    import vga_text_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [CHAR_W-1:0] BLANK = CHAR_W'(DEF_BLANK)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic [CHAR_W-1:0] o_vga_char,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [CHAR_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ready,
    output logic              o_cpu_rvalid,
    output logic [CHAR_W-1:0] o_cpu_rdata,
    input  logic              i_scroll_up,
    input  logic              i_clear_req,
    output logic              o_busy
);

    localparam int DEPTH = COLS * ROWS;
    localparam logic [ADDR_W-1:0] W_DEPTH    = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] W_COLS     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] W_LAST_ALL = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] W_LAST_ROW = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] W_TOP_BASE = ADDR_W'(DEPTH - COLS);
    localparam logic [ADDR_W:0]   W_DEPTH_X  = (ADDR_W+1)'(DEPTH);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, r_base, r_old_base;
    logic              r_pend_clr, r_pend_scr;
    logic              w_start_all, w_start_row, w_eng_we, w_last;
    logic [ADDR_W-1:0] w_eng_addr;

    logic              w_cpu_ready, w_cpu_acc, w_cpu_oor;
    logic [ADDR_W-1:0] w_cpu_phys, w_vga_phys;
    logic              w_b_we;
    logic [ADDR_W-1:0] w_b_addr;
    logic [CHAR_W-1:0] w_b_din, w_dout_a, w_dout_b;

    logic [ADDR_W-1:0] r_vga_phys;
    logic              r_vga_oor, r_vga_oor2;
    logic              r_rd_v1, r_rd_oor1, r_rvalid;
    logic [CHAR_W-1:0] r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLR_ALL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_all = 1'b0;
        w_start_row = 1'b0;
        w_eng_we    = 1'b0;
        w_eng_addr  = r_cnt;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_clear_req || r_pend_clr) begin
                    w_state_nxt = CLR_ALL;
                    w_start_all = 1'b1;
                end else if (i_scroll_up || r_pend_scr) begin
                    w_state_nxt = CLR_ROW;
                    w_start_row = 1'b1;
                end
            end
            CLR_ALL: begin
                w_eng_we = 1'b1;
                if (r_cnt == W_LAST_ALL) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            CLR_ROW: begin
                w_eng_we   = 1'b1;
                w_eng_addr = r_old_base + r_cnt;
                if (r_cnt == W_LAST_ROW) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The row being exposed at the bottom is the physical row that used to be on top.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_base     <= '0;
            r_old_base <= '0;
            r_pend_clr <= 1'b0;
            r_pend_scr <= 1'b0;
        end else if (w_start_all) begin
            r_base     <= '0;
            r_cnt      <= '0;
            r_pend_clr <= 1'b0;
        end else if (w_start_row) begin
            r_old_base <= r_base;
            r_base     <= (r_base == W_TOP_BASE) ? '0 : r_base + W_COLS;
            r_cnt      <= '0;
            r_pend_scr <= 1'b0;
        end else if (r_state != IDLE) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (i_scroll_up) begin
                r_pend_scr <= 1'b1;
            end
            if (i_clear_req && r_state == CLR_ROW) begin
                r_pend_clr <= 1'b1;
            end
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign w_cpu_ready = (r_state == IDLE) && !r_pend_clr && !r_pend_scr
                         && !i_clear_req && !i_scroll_up;
    assign o_cpu_ready = w_cpu_ready;
    assign w_cpu_acc   = i_cpu_req && w_cpu_ready;
    assign w_cpu_oor   = (i_cpu_addr >= W_DEPTH);
    assign w_cpu_phys  = log_to_phys(i_cpu_addr, r_base, W_DEPTH_X);
    assign w_vga_phys  = log_to_phys(i_vga_addr, r_base, W_DEPTH_X);

    assign w_b_we   = w_eng_we || (w_cpu_acc && i_cpu_we && !w_cpu_oor);
    assign w_b_addr = w_eng_we ? w_eng_addr : w_cpu_phys;
    assign w_b_din  = w_eng_we ? BLANK : i_cpu_wdata;

    text_ram #(
        .DEPTH  (DEPTH),
        .CHAR_W (CHAR_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk    (i_clk),
        .i_addr_a (r_vga_phys),
        .o_dout_a (w_dout_a),
        .i_we_b   (w_b_we),
        .i_addr_b (w_b_addr),
        .i_din_b  (w_b_din),
        .o_dout_b (w_dout_b)
    );

    // Out-of-range flags reset high so both read ports show BLANK straight out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vga_phys <= '0;
            r_vga_oor  <= 1'b1;
            r_vga_oor2 <= 1'b1;
            r_rd_v1    <= 1'b0;
            r_rd_oor1  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= BLANK;
        end else begin
            r_vga_phys <= w_vga_phys;
            r_vga_oor  <= (i_vga_addr >= W_DEPTH);
            r_vga_oor2 <= r_vga_oor;
            r_rd_v1    <= w_cpu_acc && !i_cpu_we;
            r_rd_oor1  <= w_cpu_oor;
            r_rvalid   <= r_rd_v1;
            if (r_rd_v1) begin
                r_rdata <= r_rd_oor1 ? BLANK : w_dout_b;
            end
        end
    end

    assign o_vga_char   = r_vga_oor2 ? BLANK : w_dout_a;
    assign o_cpu_rvalid = r_rvalid;
    assign o_cpu_rdata  = r_rdata;

endmodule
